// File: rtl/sar_frontend_emu_pkg.sv
// rtl/sar_frontend_emu_pkg.sv - shared constants and helpers for the SAR front-end emulator
package sar_frontend_emu_pkg;

  localparam int N_BITS_DEFAULT = 8;

  localparam int ERR_NO_SAMPLE = 0;
  localparam int ERR_OVERLAP   = 1;
  localparam int ERR_OVERRUN   = 2;

  // Feedback taps for x^16+x^14+x^13+x^11+1, bit 15 = x^16 term
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int sat_code(input int v, input int max_code);
    if (v < 0) return 0;
    if (v > max_code) return max_code;
    return v;
  endfunction

  function automatic int dither_val(input logic [1:0] b);
    if (b == 2'b00) return -1;
    if (b == 2'b11) return 1;
    return 0;
  endfunction

endpackage

// File: rtl/sar_frontend_emu_if.sv
// rtl/sar_frontend_emu_if.sv - controller <-> analog front-end signal bundle
import sar_frontend_emu_pkg::*;

interface sar_frontend_emu_if #(parameter int N_BITS = N_BITS_DEFAULT);
  logic [N_BITS-1:0] vin;
  logic              s_clk;
  logic              cmp_clk;
  logic [N_BITS-1:0] trial;
  logic              err_clr;
  logic              cmp_out;
  logic [N_BITS-1:0] held;
  logic              held_vld;
  logic              conv_done;
  logic [3:0]        cmp_cnt;
  logic [2:0]        err;

  modport master (
    output vin, s_clk, cmp_clk, trial, err_clr,
    input  cmp_out, held, held_vld, conv_done, cmp_cnt, err
  );

  modport slave (
    input  vin, s_clk, cmp_clk, trial, err_clr,
    output cmp_out, held, held_vld, conv_done, cmp_cnt, err
  );
endinterface

// File: rtl/sar_frontend_emu_noise_lfsr.sv
// rtl/sar_frontend_emu_noise_lfsr.sv - 16-bit Fibonacci LFSR giving a 2-bit dither selector
import sar_frontend_emu_pkg::*;

module sar_noise_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [1:0] dither_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign dither_o = lfsr_q[1:0];

endmodule

// File: rtl/sar_frontend_emu.sv
// rtl/sar_frontend_emu.sv - cycle-level S/H + CDAC + comparator responder for the SAR controller
import sar_frontend_emu_pkg::*;

module sar_frontend_emu #(
  parameter int          N_BITS    = N_BITS_DEFAULT,
  parameter int          OFFSET    = 0,
  parameter int          NOISE_EN  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic               clk,
  input logic               rst,
  sar_frontend_emu_if.slave bus
);

  localparam int MAX_CODE = (1 << N_BITS) - 1;

  logic [N_BITS-1:0] held_q, held_d;
  logic              held_vld_q, held_vld_d;
  logic              cmp_q, cmp_d;
  logic              cmp_dly_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [2:0]        err_q, err_d;

  logic [1:0] dither;
  logic       ge, cmp_rise, cmp_count;
  logic [2:0] err_new;
  int         sample_val;

  sar_noise_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en_i     ((NOISE_EN != 0) && bus.s_clk),
    .dither_o (dither)
  );

  always_comb begin
    ge         = held_q >= bus.trial;
    cmp_rise   = bus.cmp_clk & ~cmp_dly_q;
    // A compare overlapping a sample is flagged but never counted
    cmp_count  = cmp_rise & ~bus.s_clk;
    err_new                = '0;
    err_new[ERR_NO_SAMPLE] = cmp_count & ~held_vld_q;
    err_new[ERR_OVERLAP]   = bus.s_clk & bus.cmp_clk;
    err_new[ERR_OVERRUN]   = cmp_count && (cnt_q == 4'(N_BITS));
    sample_val = int'(bus.vin) + OFFSET + ((NOISE_EN != 0) ? dither_val(dither) : 0);

    held_d     = held_q;
    held_vld_d = held_vld_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    cmp_d      = bus.cmp_clk ? ge : cmp_q;

    if (bus.s_clk) begin
      held_d     = N_BITS'(sat_code(sample_val, MAX_CODE));
      held_vld_d = 1'b1;
      cnt_d      = '0;
    end else if (cmp_count) begin
      cnt_d  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      done_d = (cnt_d == 4'(N_BITS));
    end

    err_d = bus.err_clr ? err_new : (err_q | err_new);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
      cmp_q      <= 1'b0;
      cmp_dly_q  <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      cmp_q      <= cmp_d;
      cmp_dly_q  <= bus.cmp_clk;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Zero-latency comparator while evaluating, latched result otherwise
  assign bus.cmp_out   = bus.cmp_clk ? ge : cmp_q;
  assign bus.held      = held_q;
  assign bus.held_vld  = held_vld_q;
  assign bus.conv_done = done_q;
  assign bus.cmp_cnt   = cnt_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_sar_frontend_emu.sv
// tb/tb_sar_frontend_emu.sv - four front-end variants driven by a bench SAR controller
import sar_frontend_emu_pkg::*;

module tb_sar_frontend_emu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] vin = '0, trial = '0;
  logic       s_clk = 1'b0, cmp_clk = 1'b0, err_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic       o_cmp[4], o_vld[4], o_done[4];
  logic [7:0] o_held[4];
  logic [3:0] o_cnt[4];
  logic [2:0] o_err[4];

  sar_frontend_emu_if #(.N_BITS(8)) bus[4] ();

  // instance 0: plain, 1: OFFSET +3, 2: OFFSET -3, 3: noise enabled
  for (genvar k = 0; k < 4; k++) begin : g_dut
    assign bus[k].vin     = vin;
    assign bus[k].s_clk   = s_clk;
    assign bus[k].cmp_clk = cmp_clk;
    assign bus[k].trial   = trial;
    assign bus[k].err_clr = err_clr;
    assign o_cmp[k]  = bus[k].cmp_out;
    assign o_held[k] = bus[k].held;
    assign o_vld[k]  = bus[k].held_vld;
    assign o_done[k] = bus[k].conv_done;
    assign o_cnt[k]  = bus[k].cmp_cnt;
    assign o_err[k]  = bus[k].err;
    sar_frontend_emu #(
      .N_BITS    (8),
      .OFFSET    ((k == 1) ? 3 : (k == 2) ? -3 : 0),
      .NOISE_EN  ((k == 3) ? 1 : 0),
      .LFSR_SEED (16'hACE1)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[k])
    );
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [7:0]  m_held[4];
  logic        m_vld[4], m_cmpq[4], m_done[4], m_cmpd[4];
  logic [3:0]  m_cnt[4];
  logic [2:0]  m_err[4];
  logic [15:0] m_lfsr[4];
  bit          model_live = 0;
  logic        t_count;
  logic [2:0]  t_new;
  int          t_v;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_held[k] = '0; m_vld[k] = 0; m_cmpq[k] = 0; m_done[k] = 0;
        m_cmpd[k] = 0;  m_cnt[k] = '0; m_err[k] = '0; m_lfsr[k] = 16'hACE1;
      end else begin
        t_count = cmp_clk && !m_cmpd[k] && !s_clk;
        t_new = {t_count && m_cnt[k] == 4'd8, s_clk && cmp_clk, t_count && !m_vld[k]};
        if (cmp_clk) m_cmpq[k] = (m_held[k] >= trial);
        m_done[k] = 0;
        if (s_clk) begin
          t_v = int'(vin) + ((k == 1) ? 3 : (k == 2) ? -3 : 0);
          if (k == 3) begin
            if (m_lfsr[k][1:0] == 2'b00) t_v = t_v - 1;
            if (m_lfsr[k][1:0] == 2'b11) t_v = t_v + 1;
            m_lfsr[k] = {m_lfsr[k][14:0],
                         m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10]};
          end
          if (t_v < 0) t_v = 0;
          if (t_v > 255) t_v = 255;
          m_held[k] = 8'(t_v);
          m_vld[k]  = 1;
          m_cnt[k]  = 0;
        end else if (t_count) begin
          if (m_cnt[k] != 4'd15) m_cnt[k] = m_cnt[k] + 4'd1;
          m_done[k] = (m_cnt[k] == 4'd8);
        end
        m_err[k] = err_clr ? t_new : (m_err[k] | t_new);
        m_cmpd[k] = cmp_clk;
      end
    end
    if (rst) model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("cmp_out[%0d]", k), 16'(o_cmp[k]),
            16'(cmp_clk ? (m_held[k] >= trial) : m_cmpq[k]));
        chk($sformatf("held[%0d]", k), 16'(o_held[k]), 16'(m_held[k]));
        chk($sformatf("held_vld[%0d]", k), 16'(o_vld[k]), 16'(m_vld[k]));
        chk($sformatf("conv_done[%0d]", k), 16'(o_done[k]), 16'(m_done[k]));
        chk($sformatf("cmp_cnt[%0d]", k), 16'(o_cnt[k]), 16'(m_cnt[k]));
        chk($sformatf("err[%0d]", k), 16'(o_err[k]), 16'(m_err[k]));
      end
      if (o_done[0] === 1'b1) done_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_clk = 0; cmp_clk = 0; err_clr = 0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic sample();
    s_clk = 1'b1; cyc(); s_clk = 1'b0;
  endtask

  task automatic pulse();
    cmp_clk = 1'b1; cyc(); cmp_clk = 1'b0; cyc();
  endtask

  task automatic convert(input int k, output logic [7:0] code);
    s_clk = 1'b1; cyc(); cyc(); s_clk = 1'b0;
    code = '0;
    for (int b = 7; b >= 0; b--) begin
      trial = code | (8'd1 << b);
      cmp_clk = 1'b1;
      @(negedge clk);
      if (o_cmp[k]) code = trial;
      cyc();
      cmp_clk = 1'b0;
      cyc();
    end
  endtask

  logic [7:0] code;

  initial begin
    do_reset();
    chk("rst_held", 16'(o_held[0]), 16'h0);
    chk("rst_vld", 16'(o_vld[0]), 16'h0);
    chk("rst_cnt", 16'(o_cnt[0]), 16'h0);
    chk("rst_err", 16'(o_err[0]), 16'h0);
    chk("rst_cmp_out", 16'(o_cmp[0]), 16'h0);
    chk("rst_done", 16'(o_done[0]), 16'h0);

    vin = 8'hA5; done_cnt = 0;
    convert(0, code);
    cyc();
    chk("conv_code", 16'(code), 16'hA5);
    chk("conv_done_pulses", 16'(done_cnt), 16'd1);
    chk("conv_err", 16'(o_err[0]), 16'h0);

    vin = 8'hFE; sample(); cyc();
    chk("sat_hi_plus3", 16'(o_held[1]), 16'hFF);
    chk("sat_hi_plain", 16'(o_held[0]), 16'hFE);
    vin = 8'h01; sample(); cyc();
    chk("sat_lo_minus3", 16'(o_held[2]), 16'h00);
    chk("sat_lo_plus3", 16'(o_held[1]), 16'h04);

    vin = 8'd100; sample(); cyc();
    trial = 8'd100; cmp_clk = 1'b1;
    @(negedge clk); chk("cmp_eq", 16'(o_cmp[0]), 16'h1);
    cyc(); trial = 8'd101;
    @(negedge clk); chk("cmp_above", 16'(o_cmp[0]), 16'h0);
    cyc(); cmp_clk = 1'b0; trial = 8'd50;
    @(negedge clk); chk("cmp_latched", 16'(o_cmp[0]), 16'h0);
    cyc();
    chk("cmp_multi_cycle_one_count", 16'(o_cnt[0]), 16'd1);

    do_reset();
    pulse();
    chk("err_no_sample", 16'(o_err[0]), 16'h1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("err_cleared", 16'(o_err[0]), 16'h0);

    vin = 8'd100; sample(); done_cnt = 0;
    for (int i = 0; i < 8; i++) pulse();
    chk("eight_done", 16'(done_cnt), 16'd1);
    chk("eight_err", 16'(o_err[0]), 16'h0);
    pulse(); cyc();
    chk("ninth_err", 16'(o_err[0]), 16'h4);
    chk("ninth_no_done", 16'(done_cnt), 16'd1);
    chk("ninth_cnt", 16'(o_cnt[0]), 16'd9);
    s_clk = 1'b1; cmp_clk = 1'b1; cyc(); s_clk = 1'b0; cmp_clk = 1'b0;
    chk("overlap_err", 16'(o_err[0]), 16'h6);
    chk("overlap_cnt", 16'(o_cnt[0]), 16'd0);
    cyc();

    do_reset();
    vin = 8'd128;
    for (int i = 0; i < 1000; i++) begin
      convert(3, code);
      chk("noise_code_range", 16'(code >= 8'd127 && code <= 8'd129), 16'h1);
    end

    sample(); pulse(); pulse(); pulse();
    cmp_clk = 1'b1; rst = 1'b1; cyc();
    chk("midrst_vld", 16'(o_vld[0]), 16'h0);
    chk("midrst_cnt", 16'(o_cnt[0]), 16'h0);
    chk("midrst_err", 16'(o_err[0]), 16'h0);
    rst = 1'b0; cyc();
    chk("after_rst_rise_err", 16'(o_err[0]), 16'h1);
    chk("after_rst_rise_cnt", 16'(o_cnt[0]), 16'd1);
    cmp_clk = 1'b0; cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
